load_input_buffer: RTL
======================

LOAD_INPUT_BUFFER -- requirements
Module: load_input_buffer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per loaded word.
REQ-002 SHALL have parameter NUM_BITS, default 784, meaning image size in bits (28x28).
REQ-003 SHALL have parameter ADDR_W, default 10, meaning read address width; must satisfy 2^ADDR_W >= NUM_BITS.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port trigger, input, 1, meaning a one-cycle strobe marking data as a valid word.
REQ-007 SHALL have port data, input, WORD_W, meaning the load word, sampled only when trigger=1.
REQ-008 SHALL have port addr, input, ADDR_W, meaning the bit index to read.
REQ-009 SHALL have port release, input, 1, meaning a consumer pulse that frees the readable image.
REQ-010 SHALL have port q, output, 1, meaning the registered image bit at addr.
REQ-011 SHALL have port ready, output, 1, meaning a complete image is readable.
REQ-012 SHALL have port loading, output, 1, meaning a partial image is being filled (wptr != 0).
REQ-013 SHALL have port overflow, output, 1, meaning a sticky flag set when a word was dropped.

Function
REQ-014 SHALL define WORDS = ceil(NUM_BITS/WORD_W), which is 98 at the defaults.
REQ-015 SHALL map each trigger word to image bits [wptr*WORD_W +: WORD_W], LSB first, then increment wptr.
REQ-016 SHALL discard bits of the final word at indices >= NUM_BITS.
REQ-017 SHALL, on the trigger that writes word WORDS-1, wrap wptr to 0 and mark the write bank full.
REQ-018 SHALL run a write FSM with states FILL (accepting words) and FULL_WAIT (bank full, cannot be handed to the reader).
REQ-019 SHALL run a read FSM with states EMPTY (ready=0) and HOLD (ready=1).
REQ-020 SHALL assert ready exactly one cycle after the completing trigger whenever the read side is EMPTY.
REQ-021 SHALL, on release while in HOLD, return the read side to EMPTY in the next cycle unless a full bank is pending, in which case ready stays 1 and the pending bank becomes readable.
REQ-022 SHALL provide q one cycle after addr: q = image[addr] when ready=1 and addr < NUM_BITS, else 0.
REQ-023 SHALL drop any trigger arriving in FULL_WAIT, leaving contents unchanged, and set overflow to 1; overflow clears only on rst.
REQ-024 SHALL ignore a release received while EMPTY.
REQ-025 SHALL process a completing trigger and a release in the same cycle together: the new image becomes readable and ready stays 1.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set q=0, ready=0, loading=0, overflow=0, wptr=0, both FSMs to their initial states (FILL, EMPTY) and the bank select to 0.
REQ-027 SHALL, on rst mid-load or mid-read, discard the partial or held image; storage contents are not reset and are unobservable until reloaded.

Configuration
REQ-028 SHALL support macro LOAD_INPUT_DBUF_EN to select double buffering.
REQ-029 SHALL, with LOAD_INPUT_DBUF_EN defined, provide two banks: completion while HOLD enters FULL_WAIT only if the other bank is full; otherwise it swaps banks and loading continues into the free bank during reads.
REQ-030 SHALL, without LOAD_INPUT_DBUF_EN, provide one bank: completion always leads to FULL_WAIT while HOLD, and every trigger during HOLD is dropped with overflow set.

Structure
REQ-031 SHALL define in package snn_pkg the default WORD_W and NUM_BITS, a words_for(bits, width) ceiling function, and the write and read FSM state enums.
REQ-032 SHALL instantiate sub-module load_input_bank (word write port, registered single-bit read port) once without LOAD_INPUT_DBUF_EN, or twice with it.

Verification
REQ-033 SHALL cover: 98 triggers of 8'hFF -> ready=1 one cycle after the 98th trigger, never earlier; addr 0..783 -> q=1 one cycle after each address.
REQ-034 SHALL cover: 98 words of 8'b10011001 -> q at addr n equals bit n%8 of the word; addr 784..1023 -> q=0.
REQ-035 SHALL cover: 40 words, then rst, then 98 words of 8'h00 -> ready=1 after the 98th word, all q=0, overflow=0.
REQ-036 SHALL cover, single-bank build: with ready=1, 1 trigger -> overflow=1 and image unchanged; release -> ready=0 next cycle.
REQ-037 SHALL cover, DBUF build: load A=8'hC3, then load B=8'h93 while holding A -> A still reads correctly; release -> ready stays 1 and q reflects B.
REQ-038 SHALL cover, DBUF build: completing trigger and release in the same cycle -> ready stays 1, the new image is readable, and overflow=0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared defaults, word-count helper and FSM state types for the SNN image input path.
package snn_pkg;

    localparam int DEFAULT_WORD_W   = 8;
    localparam int DEFAULT_NUM_BITS = 784;

    function automatic int words_for(input int bits, input int width);
        return (bits + width - 1) / width;
    endfunction

    typedef enum logic {
        FILL,
        FULL_WAIT
    } WrState_t;

    typedef enum logic {
        EMPTY,
        HOLD
    } RdState_t;

endpackage

// File: rtl/load_input_bank.sv
// One image bank: word-wide write port and a registered single-bit read port.
// Storage is deliberately not reset; contents only become meaningful once fully reloaded.
module load_input_bank #(
    parameter int WORD_W = 8,
    parameter int WORDS  = 98,
    parameter int ADDR_W = 10,
    parameter int PTR_W  = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_wptr,
    input  logic [WORD_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_q
);

    localparam int STORE_BITS = WORDS * WORD_W;
    localparam int SPAN       = 2 ** ADDR_W;

    logic [STORE_BITS-1:0] r_bits;
    logic [SPAN-1:0]       w_readVec;
    logic                  r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int w = 0; w < WORDS; w++) begin
                if (i_wptr == PTR_W'(w)) begin
                    r_bits[w*WORD_W +: WORD_W] <= i_data;
                end
            end
        end
    end

    // Zero-extend to the full address span so every address indexes a defined bit.
    assign w_readVec = SPAN'(r_bits);

    always_ff @(posedge clk) begin
        r_q <= w_readVec[i_addr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/load_input_buffer.sv
// Assembles streamed words into a NUM_BITS image and exposes it bit-addressed to a consumer.
// Define LOAD_INPUT_DBUF_EN for two ping-pong banks; the default build uses a single bank.
// The consumer free strobe is named release_req because 'release' is a reserved word.
module load_input_buffer
    import snn_pkg::*;
#(
    parameter int WORD_W   = DEFAULT_WORD_W,
    parameter int NUM_BITS = DEFAULT_NUM_BITS,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic [WORD_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              release_req,
    output logic              q,
    output logic              ready,
    output logic              loading,
    output logic              overflow
);

    localparam int              WORDS    = words_for(NUM_BITS, WORD_W);
    localparam int              PTR_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

    WrState_t         r_wrState, w_wrStateNext;
    RdState_t         r_rdState, w_rdStateNext;
    logic [PTR_W-1:0] r_wptr, w_wptrNext;
    logic             r_overflow, w_overflowNext;
    logic             r_addrOk;
    logic             w_accept, w_complete, w_release;
    logic             w_bankQ;

`ifdef LOAD_INPUT_DBUF_EN
    // r_wrBank is the bank being filled; the readable bank is always its complement while HOLD.
    logic             r_wrBank, w_wrBankNext;
    logic             w_q0, w_q1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrState  <= FILL;
            r_rdState  <= EMPTY;
            r_wptr     <= '0;
            r_overflow <= 1'b0;
            r_addrOk   <= 1'b0;
`ifdef LOAD_INPUT_DBUF_EN
            r_wrBank   <= 1'b0;
`endif
        end else begin
            r_wrState  <= w_wrStateNext;
            r_rdState  <= w_rdStateNext;
            r_wptr     <= w_wptrNext;
            r_overflow <= w_overflowNext;
            r_addrOk   <= ({1'b0, addr} < (ADDR_W + 1)'(NUM_BITS));
`ifdef LOAD_INPUT_DBUF_EN
            r_wrBank   <= w_wrBankNext;
`endif
        end
    end

    always_comb begin
        w_wrStateNext  = r_wrState;
        w_rdStateNext  = r_rdState;
        w_wptrNext     = r_wptr;
        w_overflowNext = r_overflow;
`ifdef LOAD_INPUT_DBUF_EN
        w_wrBankNext   = r_wrBank;
`endif
        w_accept   = trigger && (r_wrState == FILL);
        w_complete = w_accept && (r_wptr == LAST_PTR);
        w_release  = release_req && (r_rdState == HOLD);

        if (w_accept) begin
            w_wptrNext = w_complete ? '0 : r_wptr + PTR_W'(1);
        end
        if (trigger && (r_wrState == FULL_WAIT)) begin
            w_overflowNext = 1'b1;
        end

`ifdef LOAD_INPUT_DBUF_EN
        // A finished bank is handed over immediately when the reader is free, else it waits.
        if (w_complete) begin
            if ((r_rdState == EMPTY) || w_release) begin
                w_rdStateNext = HOLD;
                w_wrBankNext  = ~r_wrBank;
            end else begin
                w_wrStateNext = FULL_WAIT;
            end
        end else if (w_release) begin
            if (r_wrState == FULL_WAIT) begin
                w_wrBankNext  = ~r_wrBank;
                w_wrStateNext = FILL;
            end else begin
                w_rdStateNext = EMPTY;
            end
        end
`else
        // With one bank the writer is locked out for as long as the reader holds the image.
        if (w_complete) begin
            w_rdStateNext = HOLD;
            w_wrStateNext = FULL_WAIT;
        end else if (w_release) begin
            w_rdStateNext = EMPTY;
            w_wrStateNext = FILL;
        end
`endif
    end

`ifdef LOAD_INPUT_DBUF_EN
    load_input_bank #(
        .WORD_W(WORD_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .PTR_W(PTR_W)
    ) u_bank0 (
        .clk(clk), .i_we(w_accept && !r_wrBank), .i_wptr(r_wptr),
        .i_data(data), .i_addr(addr), .o_q(w_q0)
    );

    load_input_bank #(
        .WORD_W(WORD_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .PTR_W(PTR_W)
    ) u_bank1 (
        .clk(clk), .i_we(w_accept && r_wrBank), .i_wptr(r_wptr),
        .i_data(data), .i_addr(addr), .o_q(w_q1)
    );

    assign w_bankQ = r_wrBank ? w_q0 : w_q1;
`else
    load_input_bank #(
        .WORD_W(WORD_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .PTR_W(PTR_W)
    ) u_bank0 (
        .clk(clk), .i_we(w_accept), .i_wptr(r_wptr),
        .i_data(data), .i_addr(addr), .o_q(w_bankQ)
    );
`endif

    assign ready    = (r_rdState == HOLD);
    assign loading  = (r_wptr != '0);
    assign overflow = r_overflow;
    assign q        = ready && r_addrOk && w_bankQ;

endmodule
